// File: rtl/writeback_ctrl.sv
// Writeback stage feeding the register file write port: registers ALU results
// and sequences multi-cycle data-memory loads with a bounded wait.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | accepting ALU results and load issues, stall low
// S_WAIT  | memory read requested (mem_en high), counting wait cycles
// S_WRITE | load data being written to the register file, one cycle
module writeback_ctrl #(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [REG_W-1:0]  ld_dst,
    input  logic [DATA_W-1:0] ld_addr,
    output logic              mem_en,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_write_en,
    output logic [REG_W-1:0]  rf_dst_reg,
    output logic [DATA_W-1:0] rf_dst_data,
    output logic              stall,
    output logic              ld_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [REG_W-1:0] ld_dst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            ld_dst_q    <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            rf_write_en <= 1'b0;
            rf_dst_reg  <= '0;
            rf_dst_data <= '0;
            stall       <= 1'b0;
            ld_timeout  <= 1'b0;
        end else begin
            // Write port is a one-cycle pulse; index/data read as zero otherwise.
            rf_write_en <= 1'b0;
            rf_dst_reg  <= '0;
            rf_dst_data <= '0;
            case (state)
                S_IDLE: begin
                    if (alu_valid && (alu_dst != '0)) begin
                        rf_write_en <= 1'b1;
                        rf_dst_reg  <= alu_dst;
                        rf_dst_data <= alu_data;
                    end
                    if (ld_valid) begin
                        ld_dst_q <= ld_dst;
                        wait_cnt <= '0;
                        mem_en   <= 1'b1;
                        mem_addr <= ld_addr;
                        stall    <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Data arriving on the last allowed cycle still completes the load.
                    if (mem_rdy) begin
                        mem_en   <= 1'b0;
                        mem_addr <= '0;
                        state    <= S_WRITE;
                        if (ld_dst_q != '0) begin
                            rf_write_en <= 1'b1;
                            rf_dst_reg  <= ld_dst_q;
                            rf_dst_data <= mem_rdata;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_en     <= 1'b0;
                        mem_addr   <= '0;
                        stall      <= 1'b0;
                        ld_timeout <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    stall <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mem_en   <= 1'b0;
                    mem_addr <= '0;
                    stall    <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: directed spec scenarios followed by
// randomized ALU/load traffic, checked cycle by cycle against an interval model.
module tb_writeback_ctrl;

    localparam int TO  = 16;
    localparam int INF = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_dst = '0;
    logic [15:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [3:0]  ld_dst = '0;
    logic [15:0] ld_addr = '0;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_rdy = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        rf_write_en;
    logic [3:0]  rf_dst_reg;
    logic [15:0] rf_dst_data;
    logic        stall;
    logic        ld_timeout;

    writeback_ctrl #(.DATA_W(16), .REG_W(4), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_addr(ld_addr),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .rf_write_en(rf_write_en), .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data),
        .stall(stall), .ld_timeout(ld_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  dst;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // Reference model: the single in-flight load as cycle intervals.
    int          win_lo = INF, win_hi = -1, stall_hi = -1;
    int          rdy_cyc = -1, busy_until = -1, timeout_from = INF;
    logic [15:0] rdy_data = '0, addr_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit a_v, input logic [3:0] a_d, input logic [15:0] a_data,
                        input bit l_v, input logic [3:0] l_d, input logic [15:0] l_a,
                        input int k, input logic [15:0] rd);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        alu_valid = a_v; alu_dst = a_d; alu_data = a_data;
        ld_valid  = l_v; ld_dst  = l_d; ld_addr  = l_a;
        if (c == rdy_cyc) begin
            mem_rdy = 1'b1;
            mem_rdata = rdy_data;
        end else begin
            mem_rdy = (c >= win_lo && c <= win_hi) ? 1'b0 : 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
        end
        if (c > busy_until) begin
            if (a_v && a_d != 4'd0) exp_q.push_back('{c + 1, a_d, a_data});
            if (l_v) begin
                win_lo = c + 1;
                addr_m = l_a;
                if (k >= 1 && k <= TO) begin
                    win_hi   = c + k;
                    rdy_cyc  = c + k;
                    rdy_data = rd;
                    stall_hi = c + k + 1;
                    if (l_d != 4'd0) exp_q.push_back('{c + k + 1, l_d, rd});
                end else begin
                    win_hi   = c + TO;
                    rdy_cyc  = -1;
                    stall_hi = c + TO;
                    if (timeout_from > c + TO + 1) timeout_from = c + TO + 1;
                end
                busy_until = stall_hi;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0, 1, 16'd0);
    endtask

    task automatic pulse_reset();
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        alu_valid = 1'b0; ld_valid = 1'b0; mem_rdy = 1'b0;
        #1;
        rst = 1'b1;
        win_lo = INF; win_hi = -1; stall_hi = -1; rdy_cyc = -1; timeout_from = INF;
        while (exp_q.size() > 0 && exp_q[$].cyc >= c) void'(exp_q.pop_back());
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_write_en", 32'(rf_write_en), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_until = cyc;
    endtask

    function automatic int rand_k();
        int r = int'($urandom_range(0, 9));
        if (r == 0) return 99;
        if (r == 1) return TO;
        return int'($urandom_range(1, 5));
    endfunction

    // Monitor: per-cycle output checks and write-port scoreboard.
    initial begin
        int c;
        bit in_win;
        forever begin
            @(negedge clk);
            c = cyc;
            in_win = (c >= win_lo) && (c <= win_hi);
            check("mem_en", 32'(mem_en), 32'(in_win));
            check("mem_addr", 32'(mem_addr), in_win ? 32'(addr_m) : 32'd0);
            check("stall", 32'(stall), 32'((c >= win_lo) && (c <= stall_hi)));
            check("ld_timeout", 32'(ld_timeout), 32'(c >= timeout_from));
            while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
                check("missed_write_cycle", 32'(c), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                check("write_en", 32'(rf_write_en), 32'd1);
                check("write_reg", 32'(rf_dst_reg), 32'(exp_q[0].dst));
                check("write_data", 32'(rf_dst_data), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                check("no_write_en", 32'(rf_write_en), 32'd0);
                check("idle_reg", 32'(rf_dst_reg), 32'd0);
                check("idle_data", 32'(rf_dst_data), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        busy_until = cyc;

        step(1, 4'd3, 16'hBEEF, 0, 4'd0, 16'd0, 1, 16'd0);
        idle(2);
        step(0, 4'd0, 16'd0, 1, 4'd5, 16'h0040, 3, 16'h1234);
        idle(5);
        step(1, 4'd2, 16'h0007, 1, 4'd9, 16'h0102, 2, 16'hCAFE);
        idle(4);
        step(0, 4'd0, 16'd0, 1, 4'd7, 16'h0200, 99, 16'd0);
        idle(18);
        step(0, 4'd0, 16'd0, 1, 4'd8, 16'h0300, 2, 16'h5A5A);
        idle(4);
        step(0, 4'd0, 16'd0, 1, 4'd6, 16'h0310, TO, 16'h0F0F);
        idle(TO + 3);
        step(1, 4'd0, 16'h1111, 1, 4'd0, 16'h0400, 4, 16'h2222);
        idle(6);
        step(0, 4'd0, 16'd0, 1, 4'd4, 16'h0500, 20, 16'd0);
        idle(4);
        pulse_reset();
        step(0, 4'd0, 16'd0, 1, 4'd11, 16'h0600, 2, 16'h3333);
        idle(4);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                      $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 16'($urandom),
                      rand_k(), 16'($urandom));
        end
        idle(TO + 4);
        @(negedge clk);
        #1;
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
